// File: rtl/reaction_round_ctrl_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
package rt_pkg;

    localparam int TIME_W_DEF = 12;
    localparam int LED_W      = 10;

    localparam logic [TIME_W_DEF-1:0] TIME_MAX = '1;

    localparam logic [LED_W-1:0] LED_ON   = 10'h3FF;
    localparam logic [LED_W-1:0] LED_FOUL = 10'b1010101010;
    localparam logic [LED_W-1:0] LED_OFF  = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REL    = 3'd1,
        ARM    = 3'd2,
        WAIT   = 3'd3,
        TIMING = 3'd4,
        SCORE  = 3'd5,
        FOUL   = 3'd6,
        DONE   = 3'd7
    } state_e;

    // Four-bit increment that sticks at 15.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Datapath link between the sequencer and the LFSR / down-counter / up-timer.
interface reaction_round_ctrl_if #(
    parameter int TIME_W = 12
);
    logic [TIME_W-1:0] rnd;
    logic [TIME_W-1:0] countdown;
    logic [TIME_W-1:0] elapsed;
    logic              dc_load;
    logic [TIME_W-1:0] dc_value;
    logic              dc_en;
    logic              tc_clr;
    logic              tc_en;

    // Sequencer side: reads the counters, commands them.
    modport master (
        input  rnd, countdown, elapsed,
        output dc_load, dc_value, dc_en, tc_clr, tc_en
    );

    // Counter/LFSR side.
    modport slave (
        output rnd, countdown, elapsed,
        input  dc_load, dc_value, dc_en, tc_clr, tc_en
    );
endinterface

// File: rtl/reaction_round_ctrl_btn_sync.sv
// Pushbutton synchronizer and falling-edge (press) detector.
module btn_sync_edge (
    input  logic clk,
    input  logic Reset,
    input  logic btn_n,
    output logic btn_s,
    output logic press
);
    logic sync1_q;
    logic btn_s_q;
    logic btn_prev_q;

    // Two-flop synchronizer plus one delay stage for edge detection.
    // NOTE: these flops reset to 1 (button released) so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q    <= 1'b1;
            btn_s_q    <= 1'b1;
            btn_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep each stage one clock behind the previous one.
            sync1_q    <= btn_n;
            btn_s_q    <= sync1_q;
            btn_prev_q <= btn_s_q;
        end
    end

    assign btn_s = btn_s_q;
    // High for the single cycle after btn_s falls; the FSM acts on it 3 clocks after btn_n falls.
    assign press = btn_prev_q & ~btn_s_q;
endmodule

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-time sequencer: delay, stimulus, capture, best time, false starts.
module reaction_round_ctrl
    import rt_pkg::*;
#(
    parameter int                ROUNDS    = 4,
    parameter int                TIME_W    = TIME_W_DEF,
    parameter logic [TIME_W-1:0] MIN_DELAY = TIME_W'(256)
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  btn_n,
    reaction_round_ctrl_if.master dp,
    output logic [LED_W-1:0]      LED,
    output logic [TIME_W-1:0]     result,
    output logic                  result_valid,
    output logic [TIME_W-1:0]     best,
    output logic [3:0]            round_idx,
    output logic [3:0]            foul_cnt,
    output logic                  false_start,
    output logic                  done
);
    localparam logic [TIME_W-1:0] TIME_ALL1  = {TIME_W{1'b1}};
    localparam logic [3:0]        LAST_ROUND = 4'(ROUNDS - 1);

    logic btn_s;
    logic press;

    btn_sync_edge u_btn (
        .clk   (clk),
        .Reset (Reset),
        .btn_n (btn_n),
        .btn_s (btn_s),
        .press (press)
    );

    state_e state_q, state_d;

    logic [3:0]        round_q, round_d;
    logic [3:0]        foul_q, foul_d;
    logic [TIME_W-1:0] best_q, best_d;
    logic [TIME_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;

    logic              dc_load_q, dc_load_d;
    logic              dc_en_q, dc_en_d;
    logic              tc_clr_q, tc_clr_d;
    logic              tc_en_q, tc_en_d;
    logic              false_start_q, false_start_d;
    logic              done_q, done_d;
    logic [LED_W-1:0]  led_q, led_d;

    // The delay is floored so the stimulus never comes too soon after arming.
    assign dp.dc_value = (dp.rnd < MIN_DELAY) ? MIN_DELAY : dp.rnd;

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and the game bookkeeping that changes on transitions.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        round_d        = round_q;
        foul_d         = foul_q;
        best_d         = best_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (press) begin
                    round_d = '0;
                    foul_d  = '0;
                    best_d  = TIME_ALL1;
                    state_d = REL;
                end
            end
            REL: begin
                if (btn_s) state_d = ARM;
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A press wins over an expiring delay: anticipating the light is a foul.
                if (press) begin
                    foul_d  = sat_inc4(foul_q);
                    state_d = FOUL;
                end else if (dp.countdown == '0) begin
                    state_d = TIMING;
                end
            end
            TIMING: begin
                if (press) begin
                    result_d       = dp.elapsed;
                    result_valid_d = 1'b1;
                    best_d         = (dp.elapsed < best_q) ? dp.elapsed : best_q;
                    state_d        = SCORE;
                end else if (dp.elapsed == TIME_ALL1) begin
                    // Timeout scores as all-ones, which can never beat a stored best.
                    result_d       = TIME_ALL1;
                    result_valid_d = 1'b1;
                    state_d        = SCORE;
                end
            end
            SCORE: begin
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = REL;
                end
            end
            FOUL: begin
                if (btn_s) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up with the state.
    always_comb begin
        dc_load_d     = (state_d == ARM);
        tc_clr_d      = (state_d == ARM);
        dc_en_d       = (state_d == WAIT);
        tc_en_d       = (state_d == TIMING);
        false_start_d = (state_d == FOUL);
        done_d        = (state_d == DONE);
        led_d         = LED_OFF;
        unique case (state_d)
            TIMING:  led_d = LED_ON;
            FOUL:    led_d = LED_FOUL;
            DONE:    led_d = (best_d < TIME_ALL1) ? LED_ON : LED_OFF;
            default: led_d = LED_OFF;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            round_q        <= '0;
            foul_q         <= '0;
            best_q         <= TIME_ALL1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            dc_load_q      <= 1'b0;
            dc_en_q        <= 1'b0;
            tc_clr_q       <= 1'b0;
            tc_en_q        <= 1'b0;
            false_start_q  <= 1'b0;
            done_q         <= 1'b0;
            led_q          <= LED_OFF;
        end else begin
            round_q        <= round_d;
            foul_q         <= foul_d;
            best_q         <= best_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            dc_load_q      <= dc_load_d;
            dc_en_q        <= dc_en_d;
            tc_clr_q       <= tc_clr_d;
            tc_en_q        <= tc_en_d;
            false_start_q  <= false_start_d;
            done_q         <= done_d;
            led_q          <= led_d;
        end
    end

    assign dp.dc_load   = dc_load_q;
    assign dp.dc_en     = dc_en_q;
    assign dp.tc_clr    = tc_clr_q;
    assign dp.tc_en     = tc_en_q;
    assign LED          = led_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign best         = best_q;
    assign round_idx    = round_q;
    assign foul_cnt     = foul_q;
    assign false_start  = false_start_q;
    assign done         = done_q;
endmodule
